// File: rtl/mul_array_sequencer.sv
// Sequences one multiplier array through a multi-beat dot-product job and returns a scalar result.
// Optional macro MUL_SEQ_SAT_EN: saturating accumulator plus sticky res_overflow output.
module mul_array_sequencer #(
    parameter int ARRAY_SIZE  = 16,
    parameter int NUM_WIDTH   = 8,
    parameter int MUL_LATENCY = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int MAX_BEATS   = 256
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_start,
    input  logic [$clog2(MAX_BEATS+1)-1:0]        cfg_beats,
    output logic                                  busy,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_WIDTH*ARRAY_SIZE-1:0]       in_a,
    input  logic [NUM_WIDTH*ARRAY_SIZE-1:0]       in_b,
    output logic                                  arr_reset_n,
    output logic                                  arr_enable,
    output logic [NUM_WIDTH*ARRAY_SIZE-1:0]       arr_num_1,
    output logic [NUM_WIDTH*ARRAY_SIZE-1:0]       arr_num_2,
    input  logic [2*NUM_WIDTH*ARRAY_SIZE-1:0]     arr_out_num,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ACC_WIDTH-1:0]                  res_data
`ifdef MUL_SEQ_SAT_EN
    ,
    output logic                                  res_overflow
`endif
);

    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam int LANE_W = NUM_WIDTH * ARRAY_SIZE;
    localparam int PROD_W = 2 * NUM_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(ARRAY_SIZE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       beats_r, issued_r, returned_r;
    logic [CNT_W-1:0]       beats_clamp_s;
    logic [ACC_WIDTH-1:0]   acc_r, acc_next_s;
    logic [MUL_LATENCY:0]   vpipe_r;
    logic [LANE_W-1:0]      arr_num_1_r, arr_num_2_r;
    logic                   start_s, fire_s, ret_s, in_ready_s;

    // Lossless unsigned reduction of all lane products.
    function automatic logic [SUM_W-1:0] lane_sum(input logic [ARRAY_SIZE*PROD_W-1:0] p);
        logic [SUM_W-1:0] s;
        s = {SUM_W{1'b0}};
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            s = s + SUM_W'(p[i*PROD_W +: PROD_W]);
        end
        return s;
    endfunction

    assign start_s       = (state_r == S_IDLE) && cfg_start;
    assign in_ready_s    = (state_r == S_ISSUE) && (issued_r < beats_r);
    assign fire_s        = in_valid && in_ready_s;
    assign ret_s         = vpipe_r[MUL_LATENCY];
    assign beats_clamp_s = (cfg_beats > CNT_MAX) ? CNT_MAX : cfg_beats;

    assign busy        = (state_r != S_IDLE);
    assign in_ready    = in_ready_s;
    assign arr_enable  = (state_r == S_ISSUE) || (state_r == S_DRAIN);
    assign arr_reset_n = ~reset;
    assign arr_num_1   = arr_num_1_r;
    assign arr_num_2   = arr_num_2_r;
    assign res_valid   = (state_r == S_DONE);
    assign res_data    = acc_r;

`ifdef MUL_SEQ_SAT_EN
    logic [ACC_WIDTH:0] sum_ext_s;
    logic               sat_s;
    logic               ovf_r;

    assign res_overflow = ovf_r && (state_r == S_DONE);

    // Saturating accumulate of the product group leaving the array.
    always_comb begin
        sum_ext_s = {1'b0, acc_r} + (ACC_WIDTH+1)'(lane_sum(arr_out_num));
        if (sum_ext_s[ACC_WIDTH]) begin
            acc_next_s = {ACC_WIDTH{1'b1}};
            sat_s      = 1'b1;
        end else begin
            acc_next_s = sum_ext_s[ACC_WIDTH-1:0];
            sat_s      = 1'b0;
        end
    end

    // Sticky overflow flag, cleared when a job starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (start_s) begin
            ovf_r <= 1'b0;
        end else if (ret_s && sat_s) begin
            ovf_r <= 1'b1;
        end
    end
`else
    // Wrap-around accumulate of the product group leaving the array.
    always_comb begin
        acc_next_s = acc_r + ACC_WIDTH'(lane_sum(arr_out_num));
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_start) begin
                    state_s = (cfg_beats == CNT_ZERO) ? S_DONE : S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (issued_r == beats_r) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (returned_r == beats_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Job counters, operand registers, in-flight valid pipe and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            beats_r     <= CNT_ZERO;
            issued_r    <= CNT_ZERO;
            returned_r  <= CNT_ZERO;
            acc_r       <= {ACC_WIDTH{1'b0}};
            vpipe_r     <= {(MUL_LATENCY+1){1'b0}};
            arr_num_1_r <= {LANE_W{1'b0}};
            arr_num_2_r <= {LANE_W{1'b0}};
        end else begin
            vpipe_r <= {vpipe_r[MUL_LATENCY-1:0], fire_s};
            if (fire_s) begin
                arr_num_1_r <= in_a;
                arr_num_2_r <= in_b;
                issued_r    <= issued_r + CNT_ONE;
            end
            if (start_s) begin
                beats_r    <= beats_clamp_s;
                issued_r   <= CNT_ZERO;
                returned_r <= CNT_ZERO;
                acc_r      <= {ACC_WIDTH{1'b0}};
            end else if (ret_s) begin
                acc_r      <= acc_next_s;
                returned_r <= returned_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mul_array_sequencer.sv
// Directed bench for mul_array_sequencer with a dot-product reference model and a
// behavioural multiplier array; a second instance runs with a 20-bit accumulator.
module tb_mul_array_sequencer;

    localparam int LW = 128;
    localparam int PW = 256;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic [CW-1:0] cfg_beats = '0;
    logic          in_valid = 1'b0;
    logic [LW-1:0] in_a = '0, in_b = '0;
    logic          res_ready = 1'b1;

    logic          busy, in_ready, arr_reset_n, arr_enable, res_valid;
    logic [LW-1:0] arr_num_1, arr_num_2;
    logic [31:0]   res_data;
    logic          busy20, in_ready20, arr_reset_n20, arr_enable20, res_valid20;
    logic [LW-1:0] arr_num_1_20, arr_num_2_20;
    logic [19:0]   res_data20;
    logic [PW-1:0] prod1, arr_out_num;
`ifdef MUL_SEQ_SAT_EN
    logic          res_overflow, res_overflow20;
    logic          ovf32, ovf20;
`endif

    mul_array_sequencer dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_beats(cfg_beats), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .arr_reset_n(arr_reset_n), .arr_enable(arr_enable), .arr_num_1(arr_num_1),
        .arr_num_2(arr_num_2), .arr_out_num(arr_out_num), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data)
`ifdef MUL_SEQ_SAT_EN
        , .res_overflow(res_overflow)
`endif
    );

    mul_array_sequencer #(.ACC_WIDTH(20)) dut20 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_beats(cfg_beats), .busy(busy20),
        .in_valid(in_valid), .in_ready(in_ready20), .in_a(in_a), .in_b(in_b),
        .arr_reset_n(arr_reset_n20), .arr_enable(arr_enable20), .arr_num_1(arr_num_1_20),
        .arr_num_2(arr_num_2_20), .arr_out_num(arr_out_num), .res_valid(res_valid20),
        .res_ready(res_ready), .res_data(res_data20)
`ifdef MUL_SEQ_SAT_EN
        , .res_overflow(res_overflow20)
`endif
    );

    always #5 clk = ~clk;

    int     n_tests = 0, n_fail = 0;
    bit     run_checks = 1'b0;
    longint m32, m20;
    int     exp_beats, beats_seen;
    logic [LW-1:0] last_a, last_b;

    function automatic logic [PW-1:0] mulv(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [PW-1:0] p;
        for (int i = 0; i < 16; i++) p[i*16 +: 16] = 16'(a[i*8 +: 8]) * 16'(b[i*8 +: 8]);
        return p;
    endfunction

    function automatic longint dot(input logic [LW-1:0] a, input logic [LW-1:0] b);
        longint s = 0;
        for (int i = 0; i < 16; i++) s += longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
        return s;
    endfunction

    function automatic longint acc_step(input longint acc, input longint s, input longint maxv);
`ifdef MUL_SEQ_SAT_EN
        return (acc + s > maxv) ? maxv : acc + s;
`else
        return (acc + s) & maxv;
`endif
    endfunction

    function automatic logic [LW-1:0] splat(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [LW-1:0] ramp();
        logic [LW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural multiplier array, two register stages deep.
    always @(posedge clk) begin
        prod1       <= mulv(arr_num_1, arr_num_2);
        arr_out_num <= prod1;
    end

    // Reference model: job result as the plain dot product of every accepted beat.
    always @(posedge clk) begin
        if (reset) begin
            m32 <= 0; m20 <= 0; beats_seen <= 0; exp_beats <= 0;
            last_a <= '0; last_b <= '0;
`ifdef MUL_SEQ_SAT_EN
            ovf32 <= 1'b0; ovf20 <= 1'b0;
`endif
        end else if (cfg_start && !busy) begin
            m32 <= 0; m20 <= 0; beats_seen <= 0;
            exp_beats <= (cfg_beats > 9'd256) ? 256 : int'(cfg_beats);
`ifdef MUL_SEQ_SAT_EN
            ovf32 <= 1'b0; ovf20 <= 1'b0;
`endif
        end else if (in_valid && in_ready) begin
            m32 <= acc_step(m32, dot(in_a, in_b), 64'hFFFF_FFFF);
            m20 <= acc_step(m20, dot(in_a, in_b), 64'hF_FFFF);
`ifdef MUL_SEQ_SAT_EN
            ovf32 <= ovf32 | (m32 + dot(in_a, in_b) > 64'hFFFF_FFFF);
            ovf20 <= ovf20 | (m20 + dot(in_a, in_b) > 64'hF_FFFF);
`endif
            beats_seen <= beats_seen + 1;
            last_a <= in_a;
            last_b <= in_b;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (run_checks) begin
            check("arr_reset_n", arr_reset_n, !reset);
            check("arr_num", {arr_num_1, arr_num_2}, {last_a, last_b});
            check("arr_enable", arr_enable, busy && !res_valid);
            check("ready_when_idle", in_ready && !busy, 1'b0);
            check("mirror20", {busy20, in_ready20, arr_reset_n20, arr_enable20, res_valid20,
                               arr_num_1_20, arr_num_2_20},
                              {busy, in_ready, arr_reset_n, arr_enable, res_valid, arr_num_1, arr_num_2});
            if (res_valid) begin
                check("res_data", res_data, m32);
                check("res_data20", res_data20, m20);
                check("beat_count", beats_seen, exp_beats);
`ifdef MUL_SEQ_SAT_EN
                check("res_overflow", {res_overflow, res_overflow20}, {ovf32, ovf20});
`endif
            end
        end
    end

    task automatic start_job(input int n);
        cfg_start = 1'b1;
        cfg_beats = CW'(n);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [LW-1:0] a, input logic [LW-1:0] b);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 1000; t++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        check("done_timeout", res_valid, 1'b1);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        run_checks = 1'b1;
        check("reset_outs", {busy, in_ready, arr_enable, res_valid, res_data, arr_num_1, arr_num_2}, '0);
        reset = 1'b0;
        @(negedge clk);

        // 1-beat job: 16 * 3 * 5 = 240, result 4 edges after the handshake
        start_job(1);
        send_beat(splat(8'd3), splat(8'd5));
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin k = i; break; end
        end
        check("latency_1beat", k, 4);
        check("res_1beat", res_data, 240);
        @(negedge clk);
        check("idle_after_1beat", busy, 1'b0);

        // 4 beats of 255*255 on every lane
        start_job(4);
        repeat (4) send_beat(splat(8'd255), splat(8'd255));
        check("ready_drop", {busy, in_ready}, 2'b10);
        wait_done();
        check("res_4beat", res_data, 4161600);
        @(negedge clk);

        // stalled issue pattern 1,0,0,1,0,1 with a=i, b=1
        start_job(3);
        send_beat(ramp(), splat(8'd1));
        repeat (2) @(negedge clk);
        send_beat(ramp(), splat(8'd1));
        @(negedge clk);
        send_beat(ramp(), splat(8'd1));
        wait_done();
        check("res_stall", res_data, 360);
        check("pulses_stall", beats_seen, 3);
        @(negedge clk);

        // result held under back-pressure; cfg_start ignored outside IDLE
        res_ready = 1'b0;
        start_job(1);
        send_beat(splat(8'd2), splat(8'd2));
        wait_done();
        cfg_start = 1'b1; cfg_beats = 9'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", {res_valid, in_ready, res_data}, {1'b1, 1'b0, 32'd64});
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("accept_no_restart", busy, 1'b0);
        cfg_start = 1'b0;
        @(negedge clk);
        check("still_idle", busy, 1'b0);

        // reset during DRAIN aborts the job
        start_job(4);
        repeat (4) send_beat(splat(8'd7), splat(8'd9));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort", {busy, in_ready, arr_enable, res_valid, arr_reset_n, res_data, arr_num_1, arr_num_2}, '0);
        reset = 1'b0;
        @(negedge clk);
        start_job(1);
        send_beat(splat(8'd1), splat(8'd1));
        wait_done();
        check("res_after_reset", res_data, 16);
        @(negedge clk);

        // zero-beat job returns zero immediately
        start_job(0);
        wait_done();
        check("res_zero", res_data, 0);
        @(negedge clk);
        check("idle_after_zero", busy, 1'b0);

        // 2 beats of 255*255 into the 20-bit accumulator
        start_job(2);
        repeat (2) send_beat(splat(8'd255), splat(8'd255));
        wait_done();
        check("res_2beat32", res_data, 2080800);
`ifdef MUL_SEQ_SAT_EN
        check("res_2beat20_sat", {res_overflow20, res_data20}, {1'b1, 20'd1048575});
`else
        check("res_2beat20_wrap", res_data20, 1032224);
`endif
        @(negedge clk);

        // oversized request is clamped to 256 beats
        start_job(300);
        repeat (256) send_beat(splat(8'd1), splat(8'd1));
        check("clamp_ready", in_ready, 1'b0);
        wait_done();
        check("res_clamp", res_data, 4096);
        check("beats_clamp", beats_seen, 256);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
